// File: rtl/hs_sync_pkg.sv
// Shared types and defaults for the handshake-synchronizer arbiter.
package hs_sync_pkg;

    typedef enum logic [1:0] {
        IDLE     = 2'd0,
        LAUNCH   = 2'd1,
        WAIT_ACK = 2'd2
    } state_t;

    localparam int NUM_REQ_DEF     = 4;
    localparam int TIMEOUT_CYC_DEF = 64;

    // Width of a requester ID; never narrower than one bit.
    function automatic int id_width(input int n);
        return (n <= 2) ? 1 : $clog2(n);
    endfunction

endpackage

// File: rtl/hs_sync_arbiter_rr_picker.sv
// Combinational round-robin picker: first pending bit at or after ptr, wrapping.
module rr_picker
    import hs_sync_pkg::*;
#(
    parameter int NUM_REQ = NUM_REQ_DEF,
    parameter int ID_W    = id_width(NUM_REQ)
) (
    input  logic [NUM_REQ-1:0] pending,
    input  logic [ID_W-1:0]    ptr,
    output logic               grant_valid,
    output logic [ID_W-1:0]    grant_id
);

    logic [2*NUM_REQ-1:0] doubled;
    logic [2*NUM_REQ-1:0] rotated;
    logic [ID_W:0]        offset;
    logic [ID_W:0]        sum;

    // Rotating a doubled copy puts the pointer position at bit 0.
    assign doubled = {pending, pending};
    assign rotated = doubled >> ptr;

    always_comb begin
        grant_valid = 1'b0;
        offset      = '0;
        for (int k = NUM_REQ - 1; k >= 0; k--) begin
            if (rotated[k]) begin
                grant_valid = 1'b1;
                offset      = (ID_W+1)'(k);
            end
        end
    end

    always_comb begin
        sum = {1'b0, ptr} + offset;
        if (sum >= (ID_W+1)'(NUM_REQ)) begin
            sum = sum - (ID_W+1)'(NUM_REQ);
        end
    end

    assign grant_id = sum[ID_W-1:0];

endmodule

// File: rtl/hs_sync_arbiter.sv
// Source-domain scheduler sharing one pulse synchronizer among NUM_REQ requesters.
// Optional ack timeout/abort enabled by defining HS_ARB_TIMEOUT_EN.
module hs_sync_arbiter
    import hs_sync_pkg::*;
#(
    parameter int NUM_REQ     = NUM_REQ_DEF,
    parameter int ID_W        = id_width(NUM_REQ),
    parameter int TIMEOUT_CYC = TIMEOUT_CYC_DEF
) (
    input  logic               clkA,
    input  logic               rst,
    input  logic [NUM_REQ-1:0] req_pulse,
    input  logic               ack_in,
    output logic               xfer_pulse,
    output logic [ID_W-1:0]    xfer_id,
    output logic               busy,
    output logic [NUM_REQ-1:0] pending,
    output logic [NUM_REQ-1:0] done_pulse,
    output logic [NUM_REQ-1:0] drop_err,
    output logic               timeout_err
);

    if (NUM_REQ < 2 || NUM_REQ > 16 || TIMEOUT_CYC < 2) begin : g_bad_cfg
        $error("hs_sync_arbiter: unsupported parameter set");
    end

    state_t             state_reg, state_next;
    logic [NUM_REQ-1:0] pending_reg, pending_next;
    logic [NUM_REQ-1:0] done_reg, done_next;
    logic [NUM_REQ-1:0] drop_reg, drop_next;
    logic [ID_W-1:0]    id_reg, id_next;
    logic [ID_W-1:0]    ptr_reg, ptr_next;
    logic [ID_W-1:0]    ptr_adv;
    logic               xfer_reg, busy_reg;
    logic               grant_valid;
    logic [ID_W-1:0]    grant_id;

`ifdef HS_ARB_TIMEOUT_EN
    localparam int CNT_W = $clog2(TIMEOUT_CYC + 1);
    logic [CNT_W-1:0] cnt_reg, cnt_next;
    logic             tout_reg, tout_next;
`endif

    rr_picker #(
        .NUM_REQ (NUM_REQ),
        .ID_W    (ID_W)
    ) u_picker (
        .pending     (pending_reg),
        .ptr         (ptr_reg),
        .grant_valid (grant_valid),
        .grant_id    (grant_id)
    );

    // A fresh request beats the LAUNCH clear, so it is kept rather than dropped.
    for (genvar gi = 0; gi < NUM_REQ; gi++) begin : g_req
        logic clr;
        assign clr             = (state_reg == LAUNCH) && (id_reg == ID_W'(gi));
        assign pending_next[gi] = req_pulse[gi] | (pending_reg[gi] & ~clr);
        assign drop_next[gi]    = req_pulse[gi] & pending_reg[gi] & ~clr;
    end

    assign ptr_adv = (id_reg == ID_W'(NUM_REQ - 1)) ? '0 : id_reg + 1'b1;

    always_comb begin
        state_next = state_reg;
        id_next    = id_reg;
        ptr_next   = ptr_reg;
        done_next  = '0;
`ifdef HS_ARB_TIMEOUT_EN
        tout_next  = 1'b0;
        cnt_next   = '0;
`endif
        case (state_reg)
            IDLE: begin
                if (grant_valid) begin
                    id_next    = grant_id;
                    state_next = LAUNCH;
                end
            end
            LAUNCH: begin
                state_next = WAIT_ACK;
`ifdef HS_ARB_TIMEOUT_EN
                cnt_next   = CNT_W'(1);
`endif
            end
            WAIT_ACK: begin
`ifdef HS_ARB_TIMEOUT_EN
                cnt_next = cnt_reg + 1'b1;
`endif
                if (ack_in) begin
                    done_next  = {{(NUM_REQ-1){1'b0}}, 1'b1} << id_reg;
                    ptr_next   = ptr_adv;
                    state_next = IDLE;
                end
`ifdef HS_ARB_TIMEOUT_EN
                else if (cnt_reg == CNT_W'(TIMEOUT_CYC - 1)) begin
                    tout_next  = 1'b1;
                    ptr_next   = ptr_adv;
                    state_next = IDLE;
                end
`endif
            end
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clkA or posedge rst) begin
        if (rst) begin
            state_reg   <= IDLE;
            pending_reg <= '0;
            done_reg    <= '0;
            drop_reg    <= '0;
            id_reg      <= '0;
            ptr_reg     <= '0;
            xfer_reg    <= 1'b0;
            busy_reg    <= 1'b0;
`ifdef HS_ARB_TIMEOUT_EN
            cnt_reg     <= '0;
            tout_reg    <= 1'b0;
`endif
        end else begin
            state_reg   <= state_next;
            pending_reg <= pending_next;
            done_reg    <= done_next;
            drop_reg    <= drop_next;
            id_reg      <= id_next;
            ptr_reg     <= ptr_next;
            xfer_reg    <= (state_next == LAUNCH);
            busy_reg    <= (state_next != IDLE);
`ifdef HS_ARB_TIMEOUT_EN
            cnt_reg     <= cnt_next;
            tout_reg    <= tout_next;
`endif
        end
    end

    assign xfer_pulse = xfer_reg;
    assign xfer_id    = id_reg;
    assign busy       = busy_reg;
    assign pending    = pending_reg;
    assign done_pulse = done_reg;
    assign drop_err   = drop_reg;
`ifdef HS_ARB_TIMEOUT_EN
    assign timeout_err = tout_reg;
`else
    assign timeout_err = 1'b0;
`endif

endmodule

// File: tb/tb_hs_sync_arbiter.sv
// Self-checking bench for hs_sync_arbiter: directed scenarios plus random traffic vs a reference model.
module tb_hs_sync_arbiter;

    localparam int N      = 4;
    localparam int TO_CYC = 64;
`ifdef HS_ARB_TIMEOUT_EN
    localparam bit TO_EN = 1'b1;
`else
    localparam bit TO_EN = 1'b0;
`endif

    logic         clkA = 1'b0;
    logic         rst = 1'b1;
    logic [N-1:0] req_pulse = '0;
    logic         ack_in = 1'b0;
    logic         xfer_pulse;
    logic [1:0]   xfer_id;
    logic         busy;
    logic [N-1:0] pending;
    logic [N-1:0] done_pulse;
    logic [N-1:0] drop_err;
    logic         timeout_err;

    always #5 clkA = ~clkA;

    hs_sync_arbiter dut (
        .clkA        (clkA),
        .rst         (rst),
        .req_pulse   (req_pulse),
        .ack_in      (ack_in),
        .xfer_pulse  (xfer_pulse),
        .xfer_id     (xfer_id),
        .busy        (busy),
        .pending     (pending),
        .done_pulse  (done_pulse),
        .drop_err    (drop_err),
        .timeout_err (timeout_err)
    );

    int checks = 0;
    int errors = 0;
    int cyc = 0;

    // Reference model: pending set, one in-flight transfer described by its id and launch cycle.
    logic [N-1:0] m_pend, m_done, m_drop;
    logic         m_tout, m_infl;
    int           m_id, m_launch, m_ptr;

    int got_ids[$];
    int got_launch[$];
    int drop_cnt;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        m_pend = '0; m_done = '0; m_drop = '0; m_tout = 1'b0;
        m_infl = 1'b0; m_id = 0; m_launch = 0; m_ptr = 0;
    endtask

    task automatic do_reset();
        req_pulse = '0;
        ack_in    = 1'b0;
        rst       = 1'b1;
        #1;
        chk("rst_xfer_pulse", 32'(xfer_pulse), 32'd0);
        chk("rst_xfer_id", 32'(xfer_id), 32'd0);
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_pending", 32'(pending), 32'd0);
        chk("rst_done", 32'(done_pulse), 32'd0);
        chk("rst_drop", 32'(drop_err), 32'd0);
        chk("rst_timeout", 32'(timeout_err), 32'd0);
        model_reset();
        @(posedge clkA);
        #1;
        rst = 1'b0;
        cyc = 0;
    endtask

    // One clock cycle: drive inputs, compare outputs with the model, advance the model.
    task automatic tick(input logic [N-1:0] r, input logic a);
        logic [N-1:0] clr;
        logic [N-1:0] nxt;
        bit           found;
        int           idx;
        req_pulse = r;
        ack_in    = a;
        chk("busy", 32'(busy), 32'(m_infl));
        chk("xfer_pulse", 32'(xfer_pulse), 32'(m_infl && (cyc == m_launch)));
        if (m_infl) chk("xfer_id", 32'(xfer_id), 32'(m_id));
        chk("pending", 32'(pending), 32'(m_pend));
        chk("done_pulse", 32'(done_pulse), 32'(m_done));
        chk("drop_err", 32'(drop_err), 32'(m_drop));
        chk("timeout_err", 32'(timeout_err), 32'(m_tout));
        if (xfer_pulse === 1'b1) $display("xfer cyc=%0d id=%0d", cyc, xfer_id);

        clr    = (m_infl && cyc == m_launch) ? (N'(1) << m_id) : '0;
        m_drop = r & m_pend & ~clr;
        nxt    = r | (m_pend & ~clr);
        m_done = '0;
        m_tout = 1'b0;
        if (m_infl && cyc > m_launch && a) begin
            m_done = N'(1) << m_id;
            m_infl = 1'b0;
            m_ptr  = (m_id + 1) % N;
        end else if (m_infl && TO_EN && cyc > m_launch && (cyc - m_launch) == TO_CYC - 1) begin
            m_tout = 1'b1;
            m_infl = 1'b0;
            m_ptr  = (m_id + 1) % N;
        end else if (!m_infl && m_pend != '0) begin
            found = 1'b0;
            for (int k = 0; k < N; k++) begin
                idx = (m_ptr + k) % N;
                if (!found && m_pend[idx]) begin
                    found = 1'b1;
                    m_id  = idx;
                end
            end
            m_infl   = 1'b1;
            m_launch = cyc + 1;
        end
        m_pend = nxt;
        @(posedge clkA);
        #1;
        cyc++;
    endtask

    // Serve n transfers, acking each dly cycles after launch; inj is pulsed at relative cycles at0/at1.
    task automatic run_xfers(input int n, input int dly, input logic [N-1:0] inj,
                             input int at0, input int at1);
        int           last_l;
        int           rel;
        logic [N-1:0] r;
        logic         a;
        last_l = -1000;
        rel    = 0;
        got_ids.delete();
        got_launch.delete();
        drop_cnt = 0;
        while ((got_ids.size() < n || busy === 1'b1) && rel < 300) begin
            if (xfer_pulse === 1'b1) begin
                got_ids.push_back(int'(xfer_id));
                got_launch.push_back(cyc);
                last_l = cyc;
            end
            drop_cnt += $countones(drop_err);
            r = (rel == at0 || rel == at1) ? inj : '0;
            a = (cyc == last_l + dly);
            tick(r, a);
            rel++;
        end
        chk("xfer_count", 32'(got_ids.size()), 32'(n));
    endtask

    initial begin
        int tcyc;
        logic [N-1:0] r;

        // Single request timing
        do_reset();
        repeat (3) tick('0, 1'b0);
        tick(4'b0010, 1'b0);
        chk("t1_pending", 32'(pending), 32'h2);
        tick('0, 1'b0);
        chk("t1_xfer_pulse", 32'(xfer_pulse), 32'd1);
        chk("t1_xfer_id", 32'(xfer_id), 32'd1);
        tick('0, 1'b0);
        for (int c = 6; c <= 11; c++) begin
            chk("t1_busy", 32'(busy), 32'd1);
            chk("t1_single_pulse", 32'(xfer_pulse), 32'd0);
            tick('0, 1'b0);
        end
        chk("t1_busy_ack_cycle", 32'(busy), 32'd1);
        tick('0, 1'b1);
        chk("t1_done", 32'(done_pulse), 32'h2);
        chk("t1_busy_end", 32'(busy), 32'd0);
        tick('0, 1'b0);

        // All pending: rotation 0..3 with one idle cycle between transfers
        do_reset();
        tick(4'b1111, 1'b0);
        run_xfers(4, 6, '0, -1, -1);
        for (int k = 0; k < got_ids.size() && k < 4; k++) chk("t2_order", 32'(got_ids[k]), 32'(k));
        for (int k = 1; k < got_launch.size(); k++)
            chk("t2_spacing", 32'(got_launch[k] - got_launch[k-1]), 32'd8);
        chk("t2_no_drop", 32'(drop_cnt), 32'd0);

        // Fairness wrap: after ID 2 the pointer is 3, pending 1001 -> 3 then 0
        do_reset();
        tick(4'b0100, 1'b0);
        run_xfers(3, 4, 4'b1001, 3, -1);
        if (got_ids.size() == 3) begin
            chk("t3_first", 32'(got_ids[0]), 32'd2);
            chk("t3_wrap_a", 32'(got_ids[1]), 32'd3);
            chk("t3_wrap_b", 32'(got_ids[2]), 32'd0);
        end

        // Overflow: two requests from 2 while 0 is waiting -> one drop, one transfer for 2
        do_reset();
        tick(4'b0001, 1'b0);
        run_xfers(2, 8, 4'b0100, 3, 4);
        chk("t4_drop_count", 32'(drop_cnt), 32'd1);
        if (got_ids.size() == 2) chk("t4_second_id", 32'(got_ids[1]), 32'd2);
        repeat (6) tick('0, 1'b0);

        // Re-request in the LAUNCH cycle survives the clear
        do_reset();
        tick(4'b0010, 1'b0);
        run_xfers(2, 5, 4'b0010, 1, -1);
        chk("t5_no_drop", 32'(drop_cnt), 32'd0);
        if (got_ids.size() == 2) chk("t5_repeat_id", 32'(got_ids[1]), 32'd1);
        tick('0, 1'b1);
        chk("t5_stray_ack", 32'(done_pulse), 32'd0);
        tick('0, 1'b0);

        // Asynchronous reset while waiting for the ack
        do_reset();
        tick(4'b0001, 1'b0);
        tick('0, 1'b0);
        tick('0, 1'b0);
        chk("t6_waiting", 32'(busy), 32'd1);
        #3;
        rst = 1'b1;
        #1;
        chk("t6_busy_cleared", 32'(busy), 32'd0);
        chk("t6_pending_cleared", 32'(pending), 32'd0);
        chk("t6_pulse_cleared", 32'(xfer_pulse), 32'd0);
        model_reset();
        @(posedge clkA);
        #1;
        rst = 1'b0;
        cyc++;
        tick('0, 1'b1);
        chk("t6_no_done", 32'(done_pulse), 32'd0);
        tick('0, 1'b0);

        // Ack timeout (or indefinite wait when the feature is off)
        do_reset();
        tick(4'b0001, 1'b0);
        tick('0, 1'b0);
        chk("t7_launch", 32'(xfer_pulse), 32'd1);
        tcyc = -1;
        for (int k = 0; k < 100; k++) begin
            if (tcyc < 0 && timeout_err === 1'b1) tcyc = cyc;
            tick('0, 1'b0);
        end
`ifdef HS_ARB_TIMEOUT_EN
        chk("t7_timeout_delay", 32'(tcyc - 2), 32'd64);
        tick('0, 1'b1);
        chk("t7_late_ack_ignored", 32'(done_pulse), 32'd0);
        tick(4'b0011, 1'b0);
        tick('0, 1'b0);
        chk("t7_ptr_advanced", 32'(xfer_id), 32'd1);
        run_xfers(2, 3, '0, -1, -1);
`else
        chk("t7_no_timeout", 32'(tcyc), 32'hFFFF_FFFF);
        chk("t7_still_busy", 32'(busy), 32'd1);
        tick('0, 1'b1);
        chk("t7_done", 32'(done_pulse), 32'd1);
`endif

        // Random traffic against the model
        do_reset();
        for (int k = 0; k < 1500; k++) begin
            for (int b = 0; b < N; b++) r[b] = ($urandom_range(0, 5) == 0);
            tick(r, ($urandom_range(0, 3) == 0));
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog expired at cyc=%0d", cyc);
        $fatal(1, "watchdog");
    end

endmodule

// File: doc/hs_sync_arbiter.md
Name: hs_sync_arbiter

Overview:
- Source-domain (clkA) scheduler that shares one handshake pulse synchronizer channel among NUM_REQ requesters.
- Captures single-cycle request pulses, picks one pending requester by round-robin, and launches one pulse into the synchronizer. It then blocks until the synchronizer's returned acknowledge arrives before launching the next pulse.
- Drives a stable requester ID alongside each transfer so the destination can tell which source fired.

Parameters:
- NUM_REQ, 4, number of requesters (2..16).
- ID_W, $clog2(NUM_REQ), width of the transfer ID.
- TIMEOUT_CYC, 64, clkA cycles to wait for an ack before abort (used only with the optional feature).

Ports:
- clkA  in  1  single clock, source domain.
- rst  in  1  asynchronous, active-high reset.
- req_pulse  in  NUM_REQ  one-cycle request pulse per requester.
- ack_in  in  1  one-cycle ack pulse, already synchronized back into clkA by the synchronizer feedback path.
- xfer_pulse  out  1  one-cycle pulse into the synchronizer's pulse input.
- xfer_id  out  ID_W  ID of the current transfer; stable from launch until ack.
- busy  out  1  high from launch cycle through the ack cycle.
- pending  out  NUM_REQ  per-requester pending flags.
- done_pulse  out  NUM_REQ  one-cycle completion strobe to the requester whose transfer was acked.
- drop_err  out  NUM_REQ  one-cycle strobe when a request is lost because that requester is already pending.
- timeout_err  out  1  one-cycle abort strobe (optional feature only; tied 0 otherwise).

Behaviour:
- Reset (async assert, sync release to the clkA edge): all outputs 0, pending=0, rr pointer=0, state=IDLE.
- Requests: req_pulse[i] at edge t sets pending[i] at t+1. If pending[i] is already 1 and is not cleared this cycle, the request is lost and drop_err[i]=1 at t+1.
- FSM states: IDLE, LAUNCH, WAIT_ACK.
  - IDLE: if any pending bit is set, grant the first set bit at or after the rr pointer (wrapping), register xfer_id, go to LAUNCH.
  - LAUNCH: xfer_pulse=1 for exactly this cycle, busy=1, pending[xfer_id] cleared, go to WAIT_ACK.
  - WAIT_ACK: busy=1 and xfer_id held. On ack_in: done_pulse[xfer_id]=1, rr pointer=xfer_id+1 (mod NUM_REQ), go to IDLE.
- Latency:
  - Isolated request at t → xfer_pulse at t+2, with the channel idle.
  - ack at a → next xfer_pulse no earlier than a+2, giving a minimum one-cycle gap between transfers so the synchronizer can recover.
- Simultaneous events:
  - req_pulse[i] in the same cycle that pending[i] is cleared in LAUNCH: the set wins; pending[i] stays 1 and no drop_err is raised.
  - Multiple req_pulse bits in one cycle: all are captured independently.
  - ack_in outside WAIT_ACK (IDLE/LAUNCH): ignored, no state change.
- Wrap-around: pointer NUM_REQ-1 +1 → 0. With all requesters pending, grants rotate 0,1,…,NUM_REQ-1,0.
- Reset mid-transfer: the FSM drops to IDLE and pending is cleared. No done_pulse is issued; the requester must re-request.
- xfer_pulse is never asserted while busy from a previous launch is still high, so only one transfer is in flight.

Optional Feature:
- Macro: HS_ARB_TIMEOUT_EN.
- Defined:
  - A counter starts at LAUNCH.
  - If no ack arrives within TIMEOUT_CYC cycles of WAIT_ACK, the block asserts timeout_err for 1 cycle and returns to IDLE.
  - No done_pulse is issued; the rr pointer advances past the aborted ID.
  - A late ack arriving after the abort is ignored.
- Undefined: no counter; WAIT_ACK waits indefinitely; timeout_err is tied 0.

Decomposition:
- Package hs_sync_pkg:
  - State enum (IDLE, LAUNCH, WAIT_ACK).
  - Default constants NUM_REQ_DEF=4 and TIMEOUT_CYC_DEF=64.
  - Helper function for ID width.
- One sub-module, rr_picker: combinational round-robin grant from pending and pointer. Outputs grant_valid and grant_id. The FSM and pending/pointer registers stay in the top module.

Test Plan:
- Reset then single request: req_pulse=4'b0010 at cycle 3 → xfer_pulse at cycle 5 with xfer_id=1; ack_in at cycle 12 → done_pulse=4'b0010 at cycle 13; busy high for cycles 5-12.
- All pending: req_pulse=4'b1111 at once, each ack returned 6 cycles after launch → xfer_id sequence 0,1,2,3 with a 1-cycle gap between xfer_pulses; no drop_err.
- Fairness wrap: pointer=3 after serving ID 2; pending=4'b1001 → next grant 3, then 0.
- Overflow: two req_pulse[2] pulses while ID 0 is in WAIT_ACK → drop_err[2] pulses once; exactly one transfer with ID 2 follows.
- Re-request during clear and stray ack:
  - req_pulse[1] in the same cycle as its LAUNCH → a second transfer with ID 1 follows after the ack.
  - ack_in in IDLE → no done_pulse.
- Reset mid-WAIT_ACK and timeout:
  - rst asserted mid-WAIT_ACK → outputs 0 immediately; no done_pulse.
  - With HS_ARB_TIMEOUT_EN and no ack → timeout_err 64 cycles after LAUNCH; a late ack is ignored.
